pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 255: consecutive-stall cycle count at which stall_timeout sets.
REQ-002 SHALL have parameter CNT_W, default 8: width of the consecutive-stall counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high (asserted = 1).
REQ-005 SHALL have port stallreq_if  in  1  fetch cannot deliver an instruction this cycle.
REQ-006 SHALL have port stallreq_id  in  1  decode hazard (load-use).
REQ-007 SHALL have port stallreq_ex  in  1  execute busy (multi-cycle op).
REQ-008 SHALL have port branch_flag  in  1  taken branch resolved in decode.
REQ-009 SHALL have port branch_target  in  32  branch destination.
REQ-010 SHALL have port excp_req  in  1  exception raised.
REQ-011 SHALL have port excp_handler  in  32  exception vector.
REQ-012 SHALL have port stall  out  5  hold enables: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
REQ-013 SHALL have port flush  out  1  clear IF/ID and ID/EX to zero.
REQ-014 SHALL have port new_pc  out  32  redirect address.
REQ-015 SHALL have port new_pc_valid  out  1  PC loads new_pc this cycle.
REQ-016 SHALL have port stall_timeout  out  1  sticky watchdog flag.
REQ-017 SHALL have port stall_cycles  out  32  count of cycles with stall != 0.

Function
REQ-018 SHALL compute stall combinationally, same cycle, priority ex > id > if: ex -> 5'b01111; id -> 5'b00111; if -> 5'b00011; none -> 5'b00000.
REQ-019 SHALL force stall = 0 in any cycle where excp_req = 1.
REQ-020 SHALL implement FSM states RUN, HOLD, REDIRECT.
REQ-021 SHALL transition on excp_req = 1 from any state to REDIRECT, latching excp_handler as target and clearing any pending branch.
REQ-022 SHALL, in RUN or HOLD with branch_flag = 1 and stallreq_ex = 0, go to REDIRECT latching branch_target.
REQ-023 SHALL, in RUN or HOLD with branch_flag = 1 and stallreq_ex = 1, latch branch_target as pending, set the pending flag, and go to HOLD.
REQ-024 SHALL, in RUN or HOLD with no redirect and stall != 0, go to HOLD; otherwise go to RUN.
REQ-025 SHALL, in HOLD with a pending branch and stallreq_ex = 0, go to REDIRECT using the pending target, then clear the pending flag.
REQ-026 SHALL, in REDIRECT, drive flush = 1, new_pc_valid = 1, and new_pc = latched target, for exactly one cycle.
REQ-027 SHALL make redirect latency one cycle: a request sampled at edge N gives flush/new_pc_valid in the cycle after edge N.
REQ-028 SHALL, in REDIRECT, ignore branch_flag (wrong path), accept excp_req (REDIRECT again, new target), and otherwise exit to HOLD if stall != 0, else RUN.
REQ-029 SHALL drive flush = 0 and new_pc_valid = 0 outside REDIRECT; new_pc holds the last latched target.
REQ-030 SHALL increment the CNT_W-bit consecutive counter each cycle stall != 0, saturating at 2^CNT_W-1, and clear it on any cycle with stall = 0.
REQ-031 SHALL set stall_timeout when the counter reaches STALL_LIMIT; it stays set until reset.
REQ-032 SHALL increment stall_cycles each cycle stall != 0, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-033 SHALL, on rst = 1 at a clock edge, enter RUN and clear the pending flag, target, both counters and stall_timeout.
REQ-034 SHALL hold flush = 0, new_pc_valid = 0, and new_pc = 0 while in reset; stall follows REQ-018/019 combinationally.
REQ-035 SHALL let reset asserted mid-REDIRECT or mid-HOLD abort the operation, with no redirect afterwards.

Verification
REQ-036 SHALL verify: stallreq_id = 1 for 1 cycle -> stall = 5'b00111 that cycle, stall_cycles = 1.
REQ-037 SHALL verify: branch_flag = 1, target 0x0000_0100, no stall -> next cycle flush = 1, new_pc_valid = 1, new_pc = 0x100; following cycle both 0.
REQ-038 SHALL verify: stallreq_ex high 3 cycles plus branch_flag in cycle 1 (target 0x200) -> stall = 5'b01111 for 3 cycles; redirect to 0x200 in the cycle after stallreq_ex drops.
REQ-039 SHALL verify: pending branch plus excp_req (handler 0x8000_0000) -> redirect to 0x8000_0000 only; no later 0x200 redirect.
REQ-040 SHALL verify: STALL_LIMIT = 4, stallreq_if held 4 cycles -> stall_timeout = 1 after the 4th edge; it remains 1 after the stall drops until rst.
REQ-041 SHALL verify: rst asserted during REDIRECT -> next cycle flush = 0, new_pc = 0, stall_cycles = 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the hazard/branch/exception sources and
// the pipeline hold/redirect logic.
//   master : drives stall requests, branch and exception info; receives
//            stall enables, flush, redirect PC and stall statistics.
//   slave  : the controller side (pipe_ctrl).
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        excp_req;
    logic [31:0] excp_handler;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        new_pc_valid;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex,
        output branch_flag, branch_target, excp_req, excp_handler,
        input  stall, flush, new_pc, new_pc_valid, stall_timeout, stall_cycles
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex,
        input  branch_flag, branch_target, excp_req, excp_handler,
        output stall, flush, new_pc, new_pc_valid, stall_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / redirect controller.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : pipe_ctrl_if.slave
//              in : stallreq_if/id/ex, branch_flag, branch_target,
//                   excp_req, excp_handler
//              out: stall[4:0] (bit0 PC .. bit4 MEM/WB), flush, new_pc,
//                   new_pc_valid, stall_timeout (sticky), stall_cycles
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | pipeline flowing, nothing pending
// HOLD     | previous cycle stalled; may carry a branch waiting on EX
// REDIRECT | one-cycle flush + PC load of the latched target
module pipe_ctrl #(
    parameter int STALL_LIMIT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HOLD     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        target_q, target_d;
    logic               pend_q, pend_d;
    logic [31:0]        pend_tgt_q, pend_tgt_d;
    logic [CNT_W-1:0]   cons_cnt_q, cons_cnt_d;
    logic               timeout_q, timeout_d;
    logic [31:0]        cycles_q, cycles_d;

    logic [4:0]         stall_c;
    logic               stalled;

    // An exception squashes every hold so the flush can take effect.
    always_comb begin
        stall_c = 5'b00000;
        if (!bus.excp_req) begin
            if (bus.stallreq_ex)
                stall_c = 5'b01111;
            else if (bus.stallreq_id)
                stall_c = 5'b00111;
            else if (bus.stallreq_if)
                stall_c = 5'b00011;
        end
        stalled = |stall_c;
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            ST_RUN, ST_HOLD: begin
                if (bus.excp_req) begin
                    state_d  = ST_REDIRECT;
                    target_d = bus.excp_handler;
                    pend_d   = 1'b0;
                end else if (pend_q && !bus.stallreq_ex) begin
                    // The waiting branch is older than anything now in
                    // decode, so it wins over a fresh branch_flag.
                    state_d  = ST_REDIRECT;
                    target_d = pend_tgt_q;
                    pend_d   = 1'b0;
                end else if (bus.branch_flag && !bus.stallreq_ex) begin
                    state_d  = ST_REDIRECT;
                    target_d = bus.branch_target;
                end else if (bus.branch_flag && bus.stallreq_ex) begin
                    state_d    = ST_HOLD;
                    pend_d     = 1'b1;
                    pend_tgt_d = bus.branch_target;
                end else begin
                    state_d = stalled ? ST_HOLD : ST_RUN;
                end
            end
            ST_REDIRECT: begin
                // branch_flag here comes from the wrong path and is dropped.
                if (bus.excp_req) begin
                    state_d  = ST_REDIRECT;
                    target_d = bus.excp_handler;
                    pend_d   = 1'b0;
                end else begin
                    state_d = stalled ? ST_HOLD : ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        cons_cnt_d = cons_cnt_q;
        cycles_d   = cycles_q;
        if (stalled) begin
            if (cons_cnt_q != {CNT_W{1'b1}})
                cons_cnt_d = cons_cnt_q + CNT_W'(1);
            cycles_d = cycles_q + 32'd1;
        end else begin
            cons_cnt_d = '0;
        end
        timeout_d = timeout_q | (32'(cons_cnt_d) == 32'(STALL_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            target_q   <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            cons_cnt_q <= '0;
            timeout_q  <= 1'b0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            cons_cnt_q <= cons_cnt_d;
            timeout_q  <= timeout_d;
            cycles_q   <= cycles_d;
        end
    end

    // Redirect outputs are gated by rst so a reset landing on a REDIRECT
    // cycle never lets the flush or PC load escape.
    assign bus.stall         = stall_c;
    assign bus.flush         = !rst && (state_q == ST_REDIRECT);
    assign bus.new_pc_valid  = !rst && (state_q == ST_REDIRECT);
    assign bus.new_pc        = rst ? 32'd0 : target_q;
    assign bus.stall_timeout = timeout_q;
    assign bus.stall_cycles  = cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (STALL_LIMIT = 4). Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.STALL_LIMIT(4), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.stallreq_if   = 1'b0;
        bus.stallreq_id   = 1'b0;
        bus.stallreq_ex   = 1'b0;
        bus.branch_flag   = 1'b0;
        bus.branch_target = 32'd0;
        bus.excp_req      = 1'b0;
        bus.excp_handler  = 32'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        mid();
        chk("rst_flush",   32'(bus.flush),         32'd0);
        chk("rst_npv",     32'(bus.new_pc_valid),  32'd0);
        chk("rst_new_pc",  bus.new_pc,             32'd0);
        chk("rst_cycles",  bus.stall_cycles,       32'd0);
        chk("rst_timeout", 32'(bus.stall_timeout), 32'd0);
        chk("rst_stall",   32'(bus.stall),         32'd0);

        // single id stall
        cyc_start(); rst = 1'b0; bus.stallreq_id = 1'b1;
        mid(); chk("id_stall", 32'(bus.stall), 32'h07);
        cyc_start(); idle_in();
        mid(); chk("id_cycles", bus.stall_cycles, 32'd1);
        chk("id_release", 32'(bus.stall), 32'd0);

        // plain branch to 0x100
        cyc_start(); bus.branch_flag = 1'b1; bus.branch_target = 32'h100;
        mid(); chk("br_flush_early", 32'(bus.flush), 32'd0);
        cyc_start(); idle_in();
        mid(); chk("br_flush", 32'(bus.flush), 32'd1);
        chk("br_npv", 32'(bus.new_pc_valid), 32'd1);
        chk("br_new_pc", bus.new_pc, 32'h100);
        cyc_start();
        mid(); chk("br_flush_after", 32'(bus.flush), 32'd0);
        chk("br_npv_after", 32'(bus.new_pc_valid), 32'd0);
        chk("br_pc_hold", bus.new_pc, 32'h100);

        // branch held behind a 3-cycle EX stall
        cyc_start(); bus.stallreq_ex = 1'b1; bus.branch_flag = 1'b1; bus.branch_target = 32'h200;
        mid(); chk("ex_stall_c1", 32'(bus.stall), 32'h0F);
        chk("ex_flush_c1", 32'(bus.flush), 32'd0);
        cyc_start(); bus.branch_flag = 1'b0; bus.branch_target = 32'd0;
        mid(); chk("ex_stall_c2", 32'(bus.stall), 32'h0F);
        chk("ex_flush_c2", 32'(bus.flush), 32'd0);
        cyc_start();
        mid(); chk("ex_stall_c3", 32'(bus.stall), 32'h0F);
        chk("ex_flush_c3", 32'(bus.flush), 32'd0);
        cyc_start(); idle_in();
        mid(); chk("ex_drop_stall", 32'(bus.stall), 32'd0);
        chk("ex_drop_flush", 32'(bus.flush), 32'd0);
        cyc_start();
        mid(); chk("pend_flush", 32'(bus.flush), 32'd1);
        chk("pend_npv", 32'(bus.new_pc_valid), 32'd1);
        chk("pend_new_pc", bus.new_pc, 32'h200);
        chk("pend_cycles", bus.stall_cycles, 32'd4);
        chk("pend_timeout", 32'(bus.stall_timeout), 32'd0);

        // exception overrides a pending branch
        cyc_start(); bus.stallreq_ex = 1'b1; bus.branch_flag = 1'b1; bus.branch_target = 32'h200;
        mid(); chk("xp_flush_c1", 32'(bus.flush), 32'd0);
        cyc_start(); bus.branch_flag = 1'b0; bus.excp_req = 1'b1; bus.excp_handler = 32'h8000_0000;
        mid(); chk("xp_stall_zero", 32'(bus.stall), 32'd0);
        cyc_start(); bus.excp_req = 1'b0; bus.excp_handler = 32'd0;
        mid(); chk("xp_flush", 32'(bus.flush), 32'd1);
        chk("xp_new_pc", bus.new_pc, 32'h8000_0000);
        chk("xp_stall_ex", 32'(bus.stall), 32'h0F);
        cyc_start(); idle_in();
        mid(); chk("xp_no_flush1", 32'(bus.flush), 32'd0);
        cyc_start();
        mid(); chk("xp_no_flush2", 32'(bus.flush), 32'd0);
        chk("xp_pc_hold", bus.new_pc, 32'h8000_0000);
        chk("xp_cycles", bus.stall_cycles, 32'd6);
        cyc_start();
        mid(); chk("xp_no_flush3", 32'(bus.flush), 32'd0);

        // watchdog: 4 consecutive IF stalls
        cyc_start(); bus.stallreq_if = 1'b1;
        mid(); chk("wd_stall", 32'(bus.stall), 32'h03);
        cyc_start();
        cyc_start();
        mid(); chk("wd_pre", 32'(bus.stall_timeout), 32'd0);
        cyc_start();
        mid(); chk("wd_pre4", 32'(bus.stall_timeout), 32'd0);
        cyc_start(); idle_in();
        mid(); chk("wd_set", 32'(bus.stall_timeout), 32'd1);
        chk("wd_cycles", bus.stall_cycles, 32'd10);
        cyc_start();
        cyc_start();
        mid(); chk("wd_sticky", 32'(bus.stall_timeout), 32'd1);

        // reset landing on a REDIRECT cycle
        cyc_start(); bus.branch_flag = 1'b1; bus.branch_target = 32'h300;
        cyc_start(); idle_in(); rst = 1'b1; bus.stallreq_if = 1'b1;
        mid(); chk("rr_flush_in_rst", 32'(bus.flush), 32'd0);
        chk("rr_npv_in_rst", 32'(bus.new_pc_valid), 32'd0);
        chk("rr_pc_in_rst", bus.new_pc, 32'd0);
        chk("rr_stall_in_rst", 32'(bus.stall), 32'h03);
        cyc_start(); rst = 1'b0; idle_in();
        mid(); chk("rr_flush", 32'(bus.flush), 32'd0);
        chk("rr_new_pc", bus.new_pc, 32'd0);
        chk("rr_cycles", bus.stall_cycles, 32'd0);
        chk("rr_timeout", 32'(bus.stall_timeout), 32'd0);
        cyc_start();
        mid(); chk("rr_no_redirect", 32'(bus.flush), 32'd0);

        // reset during HOLD with a pending branch
        cyc_start(); bus.stallreq_ex = 1'b1; bus.branch_flag = 1'b1; bus.branch_target = 32'h400;
        cyc_start(); bus.branch_flag = 1'b0; bus.branch_target = 32'd0; rst = 1'b1;
        cyc_start(); rst = 1'b0; idle_in();
        mid(); chk("rh_flush1", 32'(bus.flush), 32'd0);
        cyc_start();
        mid(); chk("rh_flush2", 32'(bus.flush), 32'd0);
        chk("rh_new_pc", bus.new_pc, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
